// File: rtl/mlp_host_sequencer_pkg.sv
// Shared opcodes, response constants and parser state encoding for the host sequencer.
package mlp_host_pkg;

    localparam logic [7:0] OP_LOAD_W = 8'h01;
    localparam logic [7:0] OP_LOAD_A = 8'h02;
    localparam logic [7:0] OP_RUN    = 8'h03;
    localparam logic [7:0] OP_STATUS = 8'h04;
    localparam logic [7:0] ERR_BYTE  = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_W_RST     = 4'd1,
        S_W_BYTES   = 4'd2,
        S_A_LEN     = 4'd3,
        S_A_LO      = 4'd4,
        S_A_HI      = 4'd5,
        S_RUN_START = 4'd6,
        S_RUN_WAIT  = 4'd7,
        S_TX        = 4'd8,
        S_ERR_TX    = 4'd9
    } seq_state_t;

    function automatic logic [7:0] status_byte(input logic err,
                                               input logic wready,
                                               input logic [3:0] core_state);
        return {err, wready, 2'b00, core_state};
    endfunction

endpackage

// File: rtl/mlp_host_sequencer_if.sv
// Host byte link plus MLP core load/control signals seen by the sequencer.
interface mlp_host_sequencer_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        wf_reset;
    logic        wf_push_col0;
    logic        wf_push_col1;
    logic [7:0]  wf_data_in;
    logic        init_act_valid;
    logic [15:0] init_act_data;
    logic        start_mlp;
    logic        weights_ready;
    logic [3:0]  mlp_state;
    logic        layer_complete;
    logic        acc_valid;
    logic [31:0] acc0;
    logic [31:0] acc1;
    logic        err;

    modport master (
        input  rx_valid, rx_data, tx_ready, mlp_state, layer_complete, acc_valid, acc0, acc1,
        output rx_ready, tx_valid, tx_data, wf_reset, wf_push_col0, wf_push_col1, wf_data_in,
               init_act_valid, init_act_data, start_mlp, weights_ready, err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mlp_state, layer_complete, acc_valid, acc0, acc1,
        input  rx_ready, tx_valid, tx_data, wf_reset, wf_push_col0, wf_push_col1, wf_data_in,
               init_act_valid, init_act_data, start_mlp, weights_ready, err
    );

endinterface

// File: rtl/mlp_host_sequencer_serializer.sv
// Response serializer: holds either the 64-bit {acc1,acc0} result or a single byte
// and emits it LSB-first over a valid/ready link, pulsing done on the final handshake.
module mlp_result_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_wide,
    input  logic        load_byte,
    input  logic [63:0] wide_data,
    input  logic [7:0]  byte_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done
);

    logic [63:0] shift_q, shift_d;
    logic [3:0]  count_q, count_d;
    logic        fire;

    assign tx_valid = (count_q != 4'd0);
    assign tx_data  = shift_q[7:0];
    assign fire     = tx_valid & tx_ready;
    assign done     = fire && (count_q == 4'd1);

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (load_wide) begin
            shift_d = wide_data;
            count_d = 4'd8;
        end else if (load_byte) begin
            shift_d = {56'd0, byte_data};
            count_d = 4'd1;
        end else if (fire) begin
            shift_d = {8'h00, shift_q[63:8]};
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mlp_host_sequencer.sv
// Host command sequencer: parses host packets into weight FIFO pushes, activation
// writes and run requests for the MLP core, and returns results/status as bytes.
module mlp_host_sequencer
    import mlp_host_pkg::*;
#(
    parameter int unsigned MAX_ACT_WORDS  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic            clk,
    input logic            reset,
    mlp_host_sequencer_if.master bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned WC_W = $clog2(MAX_ACT_WORDS + 1);

    seq_state_t        state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WC_W-1:0]   len_q, len_d;
    logic [7:0]        lo_q, lo_d;
    logic [31:0]       acc0_q, acc0_d;
    logic [31:0]       acc1_q, acc1_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic              err_q, err_d;
    logic              wready_q, wready_d;
    logic              push0_q, push0_d;
    logic              push1_q, push1_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              act_v_q, act_v_d;
    logic [15:0]       act_data_q, act_data_d;
    logic              status_q, status_d;
    logic              ready_en_q;

    logic              accept_state;
    logic              rx_ready;
    logic              rx_fire;
    logic              err_set, err_clr;
    logic              ser_load_wide, ser_load_byte, ser_done;
    logic [7:0]        ser_byte;

    assign accept_state = (state_q == S_IDLE)  || (state_q == S_W_BYTES) ||
                          (state_q == S_A_LEN) || (state_q == S_A_LO)    ||
                          (state_q == S_A_HI);
    // Held low for the first cycle out of reset so every output reads 0 while reset is asserted.
    assign rx_ready = ready_en_q & accept_state;
    assign rx_fire  = bus.rx_valid & rx_ready;

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_cnt_d    = word_cnt_q;
        len_d         = len_q;
        lo_d          = lo_q;
        acc0_d        = acc0_q;
        acc1_d        = acc1_q;
        tmo_d         = tmo_q;
        wready_d      = wready_q;
        push0_d       = 1'b0;
        push1_d       = 1'b0;
        wdata_d       = wdata_q;
        act_v_d       = 1'b0;
        act_data_d    = act_data_q;
        status_d      = status_q;
        err_set       = 1'b0;
        err_clr       = 1'b0;
        ser_load_wide = 1'b0;
        ser_load_byte = 1'b0;
        ser_byte      = ERR_BYTE;

        if (state_q == S_RUN_WAIT && bus.acc_valid) begin
            acc0_d = bus.acc0;
            acc1_d = bus.acc1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    status_d = 1'b0;
                    case (bus.rx_data)
                        OP_LOAD_W: state_d = S_W_RST;
                        OP_LOAD_A: state_d = S_A_LEN;
                        OP_RUN:    state_d = S_RUN_START;
                        OP_STATUS: begin
                            ser_load_byte = 1'b1;
                            ser_byte      = status_byte(err_q, wready_q, bus.mlp_state);
                            status_d      = 1'b1;
                            state_d       = S_TX;
                        end
                        default: begin
                            err_set       = 1'b1;
                            ser_load_byte = 1'b1;
                            state_d       = S_ERR_TX;
                        end
                    endcase
                end
            end
            S_W_RST: begin
                wready_d   = 1'b0;
                byte_cnt_d = 2'd0;
                state_d    = S_W_BYTES;
            end
            S_W_BYTES: begin
                if (rx_fire) begin
                    wdata_d    = bus.rx_data;
                    push0_d    = ~byte_cnt_q[1];
                    push1_d    = byte_cnt_q[1];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wready_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_A_LEN: begin
                if (rx_fire) begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > 8'(MAX_ACT_WORDS)) begin
                        err_set       = 1'b1;
                        ser_load_byte = 1'b1;
                        state_d       = S_ERR_TX;
                    end else begin
                        len_d      = WC_W'(bus.rx_data);
                        word_cnt_d = '0;
                        state_d    = S_A_LO;
                    end
                end
            end
            S_A_LO: begin
                if (rx_fire) begin
                    lo_d    = bus.rx_data;
                    state_d = S_A_HI;
                end
            end
            S_A_HI: begin
                if (rx_fire) begin
                    act_v_d    = 1'b1;
                    act_data_d = {bus.rx_data, lo_q};
                    word_cnt_d = word_cnt_q + WC_W'(1);
                    state_d    = (word_cnt_d == len_q) ? S_IDLE : S_A_LO;
                end
            end
            S_RUN_START: begin
                tmo_d   = '0;
                state_d = S_RUN_WAIT;
            end
            S_RUN_WAIT: begin
                if (bus.layer_complete) begin
                    wready_d      = 1'b0;
                    ser_load_wide = 1'b1;
                    state_d       = S_TX;
                end else if (tmo_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_set       = 1'b1;
                    ser_load_byte = 1'b1;
                    state_d       = S_ERR_TX;
                end else begin
                    tmo_d = tmo_q + TO_W'(1);
                end
            end
            S_TX, S_ERR_TX: begin
                if (ser_done) begin
                    err_clr  = status_q;
                    status_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new error raised together with a status read wins over the clear.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            lo_q       <= '0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            wready_q   <= 1'b0;
            push0_q    <= 1'b0;
            push1_q    <= 1'b0;
            wdata_q    <= '0;
            act_v_q    <= 1'b0;
            act_data_q <= '0;
            status_q   <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            lo_q       <= lo_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            wready_q   <= wready_d;
            push0_q    <= push0_d;
            push1_q    <= push1_d;
            wdata_q    <= wdata_d;
            act_v_q    <= act_v_d;
            act_data_q <= act_data_d;
            status_q   <= status_d;
            ready_en_q <= 1'b1;
        end
    end

    mlp_result_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .load_wide (ser_load_wide),
        .load_byte (ser_load_byte),
        .wide_data ({acc1_d, acc0_d}),
        .byte_data (ser_byte),
        .tx_valid  (bus.tx_valid),
        .tx_data   (bus.tx_data),
        .tx_ready  (bus.tx_ready),
        .done      (ser_done)
    );

    assign bus.rx_ready       = rx_ready;
    assign bus.wf_reset       = (state_q == S_W_RST);
    assign bus.wf_push_col0   = push0_q;
    assign bus.wf_push_col1   = push1_q;
    assign bus.wf_data_in     = wdata_q;
    assign bus.init_act_valid = act_v_q;
    assign bus.init_act_data  = act_data_q;
    assign bus.start_mlp      = (state_q == S_RUN_START);
    assign bus.weights_ready  = wready_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_mlp_host_sequencer.sv
// Directed bench for mlp_host_sequencer: host packets in, FIFO/activation/start and response bytes checked.
module tb_mlp_host_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mlp_host_sequencer_if bus();

    mlp_host_sequencer #(
        .MAX_ACT_WORDS  (16),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  tx_q[$];
    logic [7:0]  col0_q[$];
    logic [7:0]  col1_q[$];
    logic [15:0] act_q[$];
    int wf_reset_cnt = 0;
    int start_cnt = 0;
    int conflict_cnt = 0;
    int stall_viol = 0;
    int rx_stuck = 0;
    bit stall_mode = 1'b0;
    bit core_en = 1'b0;
    int core_cnt = 0;
    bit hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;

    function automatic logic [40:0] outs_vec();
        return {bus.rx_ready, bus.tx_valid, bus.tx_data, bus.wf_reset, bus.wf_push_col0,
                bus.wf_push_col1, bus.wf_data_in, bus.init_act_valid, bus.init_act_data,
                bus.start_mlp, bus.weights_ready, bus.err};
    endfunction

    // Host-side receiver, event monitor and a small core model, all on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (hold_pend && bus.tx_valid && bus.tx_data !== hold_data) stall_viol++;
            bus.tx_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            hold_pend = bus.tx_valid && !bus.tx_ready;
            hold_data = bus.tx_data;
            if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
            if (bus.wf_reset) wf_reset_cnt++;
            if (bus.wf_push_col0) col0_q.push_back(bus.wf_data_in);
            if (bus.wf_push_col1) col1_q.push_back(bus.wf_data_in);
            if (bus.init_act_valid) act_q.push_back(bus.init_act_data);
            if (bus.start_mlp) start_cnt++;
            if ((int'(bus.wf_push_col0) + int'(bus.wf_push_col1) + int'(bus.init_act_valid)) > 1)
                conflict_cnt++;
            bus.acc_valid = 1'b0;
            bus.layer_complete = 1'b0;
            if (core_en) begin
                if (bus.start_mlp) core_cnt = 5;
                else if (core_cnt > 0) core_cnt--;
                if (core_cnt == 4) begin
                    bus.acc_valid = 1'b1; bus.acc0 = 32'h55; bus.acc1 = 32'h66;
                end else if (core_cnt == 2) begin
                    bus.acc_valid = 1'b1; bus.acc0 = 32'h13; bus.acc1 = -32'sd2;
                end else if (core_cnt == 1) begin
                    bus.layer_complete = 1'b1;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        while (!bus.rx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) rx_stuck++;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int limit, output int cycles);
        cycles = 0;
        while (tx_q.size() < n && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (outs_vec() !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required 0", outs_vec());
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.rx_ready !== 1'b1 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready: rx_ready=%b err=%b required 1/0", bus.rx_ready, bus.err);
        end
    endtask

    task automatic test_load_w();
        int r0 = wf_reset_cnt;
        col0_q.delete(); col1_q.delete();
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        repeat (3) @(negedge clk);
        vectors++;
        if (wf_reset_cnt - r0 != 1) begin
            miscompares++;
            $display("FAIL wf_reset_pulse: got %0d cycles required 1", wf_reset_cnt - r0);
        end
        vectors++;
        if (col0_q.size() != 2 || col0_q[0] !== 8'h11 || col0_q[1] !== 8'h22) begin
            miscompares++;
            $display("FAIL col0_push: got n=%0d %h %h required 2 11 22", col0_q.size(), col0_q[0], col0_q[1]);
        end
        vectors++;
        if (col1_q.size() != 2 || col1_q[0] !== 8'h33 || col1_q[1] !== 8'h44) begin
            miscompares++;
            $display("FAIL col1_push: got n=%0d %h %h required 2 33 44", col1_q.size(), col1_q[0], col1_q[1]);
        end
        vectors++;
        if (bus.weights_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL weights_ready_set: got %b required 1", bus.weights_ready);
        end
    endtask

    task automatic test_load_a();
        act_q.delete();
        send_byte(8'h02); send_byte(8'h02);
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
        repeat (3) @(negedge clk);
        vectors++;
        if (act_q.size() != 2 || act_q[0] !== 16'h1234 || act_q[1] !== 16'h5678) begin
            miscompares++;
            $display("FAIL act_words: got n=%0d %h %h required 2 1234 5678", act_q.size(), act_q[0], act_q[1]);
        end
        vectors++;
        if (conflict_cnt != 0 || rx_stuck != 0) begin
            miscompares++;
            $display("FAIL strobe_overlap: got overlap=%0d stuck=%0d required 0/0", conflict_cnt, rx_stuck);
        end
    endtask

    task automatic test_run();
        logic [7:0] exp_b[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
        int s0 = start_cnt;
        int cyc;
        tx_q.delete();
        stall_mode = 1'b1;
        core_en = 1'b1;
        send_byte(8'h03);
        wait_tx(8, 3000, cyc);
        stall_mode = 1'b0;
        core_en = 1'b0;
        vectors++;
        if (tx_q.size() != 8) begin
            miscompares++;
            $display("FAIL run_tx_count: got %0d bytes required 8", tx_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tx_q[i] !== exp_b[i]) begin
                miscompares++;
                $display("FAIL run_tx_byte%0d: got %h required %h", i, tx_q[i], exp_b[i]);
            end
        end
        vectors++;
        if (start_cnt - s0 != 1) begin
            miscompares++;
            $display("FAIL start_pulse: got %0d cycles required 1", start_cnt - s0);
        end
        vectors++;
        if (stall_viol != 0) begin
            miscompares++;
            $display("FAIL tx_hold: got %0d changes under stall required 0", stall_viol);
        end
        vectors++;
        if (bus.weights_ready !== 1'b0 || bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL run_done: weights_ready=%b tx_valid=%b required 0/0", bus.weights_ready, bus.tx_valid);
        end
    endtask

    task automatic test_errors();
        int a0 = act_q.size();
        int cyc;
        logic [7:0] pkt[3][2] = '{'{8'h02, 8'h00}, '{8'h02, 8'h11}, '{8'h7F, 8'h00}};
        bus.mlp_state = 4'h3;
        for (int i = 0; i < 3; i++) begin
            tx_q.delete();
            send_byte(pkt[i][0]);
            if (i < 2) send_byte(pkt[i][1]);
            wait_tx(1, 200, cyc);
            vectors++;
            if (tx_q.size() != 1 || tx_q[0] !== 8'hEE || bus.err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_case%0d: got n=%0d byte=%h err=%b required 1 ee 1", i, tx_q.size(), tx_q[0], bus.err);
            end
        end
        vectors++;
        if (act_q.size() != a0) begin
            miscompares++;
            $display("FAIL err_no_act: got %0d extra words required 0", act_q.size() - a0);
        end
        tx_q.delete();
        send_byte(8'h04);
        wait_tx(1, 200, cyc);
        vectors++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h83 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL status_clear: got n=%0d byte=%h err=%b required 1 83 0", tx_q.size(), tx_q[0], bus.err);
        end
    endtask

    task automatic test_timeout();
        int s0 = start_cnt;
        int cyc;
        tx_q.delete();
        bus.mlp_state = 4'h3;
        send_byte(8'h03);
        wait_tx(1, 1500, cyc);
        vectors++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hEE || cyc < 1020 || cyc > 1032) begin
            miscompares++;
            $display("FAIL timeout_err: got n=%0d byte=%h after %0d cycles required ee near 1024", tx_q.size(), tx_q[0], cyc);
        end
        vectors++;
        if (start_cnt - s0 != 1 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_state: starts=%0d err=%b required 1/1", start_cnt - s0, bus.err);
        end
        for (int i = 0; i < 2; i++) begin
            tx_q.delete();
            send_byte(8'h04);
            wait_tx(1, 200, cyc);
            vectors++;
            if (tx_q.size() != 1 || tx_q[0] !== (i == 0 ? 8'h83 : 8'h03)) begin
                miscompares++;
                $display("FAIL timeout_status%0d: got n=%0d byte=%h required %h", i, tx_q.size(), tx_q[0], (i == 0 ? 8'h83 : 8'h03));
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int cyc;
        col1_q.delete();
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (outs_vec() !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got %h required 0", outs_vec());
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.mlp_state = 4'h5;
        tx_q.delete();
        send_byte(8'h04);
        wait_tx(1, 200, cyc);
        vectors++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h05 || col1_q.size() != 0) begin
            miscompares++;
            $display("FAIL post_reset_status: got n=%0d byte=%h col1=%0d required 1 05 0", tx_q.size(), tx_q[0], col1_q.size());
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        bus.tx_ready = 1'b1;
        bus.mlp_state = 4'h0;
        bus.layer_complete = 1'b0;
        bus.acc_valid = 1'b0;
        bus.acc0 = 32'h0;
        bus.acc1 = 32'h0;
        test_reset();
        test_load_w();
        test_load_a();
        test_run();
        test_errors();
        test_timeout();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
